// File: rtl/core_pkg.sv
// Shared fetch-side definitions: default widths, NOP encoding and the fetch
// sequencer state type.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; used both as the instruction buffer and as the
// in-order queue of issued fetch PCs.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  // Next pointers/count; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    do_pop_s  = pop_i && (cnt_q != {CW{1'b0}});
    do_push_s = push_i && ((cnt_q != FULL_CNT) || do_pop_s);
    if (clr_i) begin
      wptr_d = {AW{1'b0}};
      rptr_d = {AW{1'b0}};
      cnt_d  = {CW{1'b0}};
    end else begin
      wptr_d = do_push_s ? wptr_q + AW'(1) : wptr_q;
      rptr_d = do_pop_s  ? rptr_q + AW'(1) : rptr_q;
      cnt_d  = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr_i) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC ownership, in-order imem requests, redirect
// squash/flush and a buffered valid/ready interface towards decode.
module fetch_unit
  import core_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            if_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
  localparam int BW = XLEN + 32;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;

  logic [BW-1:0]   buf_dout_s;
  logic [CW-1:0]   buf_cnt_s;
  logic            buf_empty_s;
  logic [XLEN-1:0] pcq_dout_s;
  logic [CW-1:0]   pcq_cnt_s;
  logic            pcq_empty_s;

  logic [OW-1:0]   occ_s;
  logic            if_valid_s, pop_s, req_s, gnt_s, rsp_s, live_rsp_s, pcq_pop_s;

  // Handshakes and credit. Live requests equal the PC-queue count while in RUN,
  // and a same-cycle decode pop frees a slot so streaming has no bubbles.
  always_comb begin
    if_valid_s = !buf_empty_s && !redirect_i;
    pop_s      = if_valid_s && if_ready_i;
    occ_s      = OW'(pcq_cnt_s) + OW'(buf_cnt_s) - OW'(pop_s);
    req_s      = (state_q == FETCH_RUN) && !redirect_i && (occ_s < DEPTH_O);
    gnt_s      = req_s && imem_gnt_i;
    rsp_s      = imem_rvalid_i && (out_q != {CW{1'b0}});
    pcq_pop_s  = rsp_s && (state_q == FETCH_RUN);
    live_rsp_s = pcq_pop_s && !redirect_i && !pcq_empty_s;
  end

  // Next PC, outstanding count and sequencer state.
  always_comb begin
    out_d = out_q + CW'(gnt_s) - CW'(rsp_s);
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~XLEN'(3);
    end else if (gnt_s) begin
      pc_d = pc_q + XLEN'(4);
    end else begin
      pc_d = pc_q;
    end
    if (redirect_i) begin
      state_d = (out_d != {CW{1'b0}}) ? FETCH_FLUSH : FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_RUN:   state_d = FETCH_RUN;
        FETCH_FLUSH: state_d = (out_d == {CW{1'b0}}) ? FETCH_RUN : FETCH_FLUSH;
        default:     state_d = FETCH_RUN;
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      out_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pcq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect_i),
    .push_i  (gnt_s),
    .din_i   (pc_q),
    .pop_i   (pcq_pop_s),
    .dout_o  (pcq_dout_s),
    .count_o (pcq_cnt_s),
    .empty_o (pcq_empty_s)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(BW)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect_i),
    .push_i  (live_rsp_s),
    .din_i   ({pcq_dout_s, imem_rdata_i}),
    .pop_i   (pop_s),
    .dout_o  (buf_dout_s),
    .count_o (buf_cnt_s),
    .empty_o (buf_empty_s)
  );

  // Request is held low throughout reset even though RUN is the reset state.
  assign imem_req_o  = req_s && rst_n;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_s;
  assign if_pc_o     = buf_empty_s ? {XLEN{1'b0}} : buf_dout_s[BW-1:32];
  assign if_instr_o  = buf_empty_s ? 32'h0 : buf_dout_s[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every
// cycle, plus literal expectations for reset, stall, redirect and flush cases.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        imem_req, imem_gnt = 1'b1, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        if_valid, if_ready = 1'b1;
  logic [31:0] if_instr, if_pc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] m_live[$];
  logic [31:0] m_buf[$];
  int          m_stale = 0;
  logic [31:0] m_pc = 32'h0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redir), .redirect_pc_i(rpc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .if_valid_o(if_valid), .if_instr_o(if_instr), .if_pc_o(if_pc),
    .if_ready_i(if_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: answers granted requests in order after lat cycles.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Per-cycle comparison against the reference model, then model advance.
  initial forever begin
    bit exp_valid, exp_req, pop;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, if_valid}, 32'h0);
      check("rst_pc", if_pc, 32'h0);
      check("rst_instr", if_instr, 32'h0);
      mem_q.delete(); m_live.delete(); m_buf.delete();
      m_stale = 0; m_pc = 32'h0;
    end else begin
      exp_valid = (m_buf.size() > 0) && !redir;
      pop       = exp_valid && if_ready;
      exp_req   = !redir && (m_stale == 0) &&
                  (m_live.size() + m_buf.size() - (pop ? 1 : 0) < DEPTH);
      check("req", {31'h0, imem_req}, {31'h0, exp_req});
      if (exp_req) check("addr", imem_addr, m_pc);
      check("valid", {31'h0, if_valid}, {31'h0, exp_valid});
      if (exp_valid) begin
        check("if_pc", if_pc, m_buf[0]);
        check("if_instr", if_instr, word_of(m_buf[0]));
      end
      if (imem_req && imem_gnt) mem_q.push_back('{imem_addr, cyc + lat});
      if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (pop) void'(m_buf.pop_front());
      if (imem_rvalid) begin
        if (m_stale > 0) m_stale--;
        else if (m_live.size() > 0) begin
          logic [31:0] p;
          p = m_live.pop_front();
          if (!redir) m_buf.push_back(p);
        end
      end
      if (exp_req && imem_gnt) begin
        m_live.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (redir) begin
        m_pc = rpc & 32'hFFFF_FFFC;
        m_buf.delete();
        m_stale += m_live.size();
        m_live.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if_valid) break;
    end
    check({name, "_valid"}, {31'h0, if_valid}, 32'h1);
    check({name, "_pc"}, if_pc, exp_pc);
  endtask

  initial begin
    @(negedge clk);
    check("t0_req", {31'h0, imem_req}, 32'h0);
    check("t0_valid", {31'h0, if_valid}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    // Stream from reset with single-cycle memory.
    @(negedge clk);
    check("t1_first_req", {31'h0, imem_req}, 32'h1);
    check("t1_first_addr", imem_addr, 32'h0);
    wait_valid("t1_first", 32'h0);
    @(negedge clk);
    check("t1_second_pc", if_pc, 32'h4);
    // Decode stalls: buffer fills to DEPTH, requests stop.
    step();
    if_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("t2_req_off", {31'h0, imem_req}, 32'h0);
    check("t2_head_pc", if_pc, 32'h8);
    step();
    if_ready = 1'b1;
    @(negedge clk);
    check("t2_resume_pc", if_pc, 32'h8);
    @(negedge clk);
    check("t2_next_pc", if_pc, 32'hC);
    // Two in flight, redirect to 0x100 squashes them.
    step();
    lat = 3;
    for (int i = 0; i < 20 && m_live.size() != 2; i++) step();
    check("t3_two_live", m_live.size(), 32'd2);
    redir = 1'b1; rpc = 32'h100;
    step();
    redir = 1'b0;
    wait_valid("t3_target", 32'h100);
    // Idle redirect to an unaligned target.
    step();
    if_ready = 1'b0;
    repeat (12) step();
    redir = 1'b1; rpc = 32'h203;
    step();
    redir = 1'b0;
    @(negedge clk);
    check("t4_req", {31'h0, imem_req}, 32'h1);
    check("t4_addr", imem_addr, 32'h200);
    step();
    lat = 1; if_ready = 1'b1;
    repeat (6) step();
    // Redirect during steady grant+response traffic.
    redir = 1'b1; rpc = 32'h300;
    @(negedge clk);
    check("t5_req_forced", {31'h0, imem_req}, 32'h0);
    step();
    redir = 1'b0;
    @(negedge clk);
    check("t5_buf_empty", {31'h0, if_valid}, 32'h0);
    check("t5_addr", imem_addr, 32'h300);
    step();
    // Back-to-back redirects while flushing.
    lat = 4;
    repeat (3) step();
    for (int i = 0; i < 20 && m_live.size() == 0; i++) step();
    redir = 1'b1; rpc = 32'h40;
    step();
    rpc = 32'h80;
    step();
    redir = 1'b0;
    wait_valid("t6_target", 32'h80);
    // Reset in the middle of traffic.
    step();
    lat = 1;
    repeat (5) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_req", {31'h0, imem_req}, 32'h1);
    check("t7_addr", imem_addr, 32'h0);
    wait_valid("t7_restart", 32'h0);
    step();
    repeat (8) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
